fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the main decoder.
- Holds the PC and issues word requests to instruction memory over a valid/ready request channel, with a one-cycle-or-later response channel.
- Buffers returned instructions in a small queue and presents instruction, PC, PC+4 and the 7-bit opcode to the decode stage over a valid/ready handshake.
- Accepts branch/jal redirects from execute and discards stale fetches.

Parameters:
- XLEN, 32, width of PC and instruction words.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- QDEPTH, 2, instruction-queue entries; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  XLEN  fetch address; low 2 bits always 0.
- imem_rsp_valid  input  1  response data valid; arrives at least 1 cycle after the request handshake.
- imem_rsp_data  input  XLEN  fetched instruction word.
- redirect_valid  input  1  taken branch or jal from execute.
- redirect_pc  input  XLEN  new fetch target.
- id_valid  output  1  queue head valid toward the decoder.
- id_ready  input  1  decoder consumes the head this cycle.
- id_instr  output  XLEN  head instruction.
- id_pc  output  XLEN  address of the head instruction.
- id_pc_plus4  output  XLEN  id_pc + 4, modulo 2^XLEN.
- id_op  output  7  id_instr[6:0], feeds the main decoder OP input.

Behaviour:
- Reset (sync, highest priority over every other event, including mid-transaction):
  - pc=RESET_PC, FSM=REQ, queue emptied, count=0.
  - imem_req_valid=0 and id_valid=0 during the reset cycle.
  - Any response arriving after reset for a pre-reset request is ignored; memory is reset together with this block.
- Only one outstanding request at a time.
- FSM states REQ, WAIT, DROP:
  - REQ:
    - imem_req_valid=1 iff count<QDEPTH; imem_req_addr=pc.
    - On a request handshake: latch req_pc=pc, pc<=pc+4 (wraps modulo 2^XLEN), go to WAIT.
  - WAIT:
    - imem_req_valid=0.
    - On imem_rsp_valid: push {imem_rsp_data, req_pc} into the queue, go to REQ.
  - DROP:
    - imem_req_valid=0.
    - On imem_rsp_valid: discard the data, go to REQ.
- Queue:
  - Registered; id_valid asserts the cycle after the push (fetch latency: request handshake -> response -> +1 cycle to id_valid).
  - Pop on id_valid&id_ready. Simultaneous push and pop leaves count unchanged.
  - Overflow is impossible by construction: a request is issued only when count<QDEPTH, and pops only free space.
  - id_* outputs are stable while id_valid=1 and id_ready=0.
- Redirect (redirect_valid=1), priority below reset:
  - pc<=redirect_pc with bits[1:0] forced to 0.
  - Queue flushed, so id_valid=0 next cycle; a concurrent pop or push is discarded.
  - In REQ with a concurrent request handshake -> go to DROP.
  - In REQ without a handshake -> stay in REQ.
  - In WAIT without imem_rsp_valid -> go to DROP.
  - In WAIT with imem_rsp_valid -> discard the data, go to REQ.
  - In DROP -> stay in DROP; still exactly one response is pending.
  - The request on the next cycle uses the new pc. A redirect may change imem_req_addr while imem_req_valid=1 and not accepted; memory tolerates this.
- Back-to-back redirects: the last one wins; only one pending response is ever dropped.
- Throughput: at most 1 instruction per 2 cycles with a 1-cycle memory.

Test Plan:
- Reset, then imem_req_ready=1 and a 1-cycle response returning 0x00000013, 0x00500093, ... with id_ready=1 -> request addresses 0x0, 0x4, 0x8; id_pc=0x0 with id_op=7'h13, then id_pc=0x4 with id_pc_plus4=0x8.
- Hold id_ready=0 -> exactly QDEPTH (2) requests issued, then imem_req_valid stays 0. Raise id_ready -> heads at 0x0 then 0x4 in order and fetching resumes at 0x8.
- Redirect to 0x100 while in WAIT with no response -> next response (0xDEADBEEF) dropped and never shown on id; next request address 0x100.
- Redirect to 0x200 in the same cycle as imem_rsp_valid, with the queue holding one entry -> id_valid=0 next cycle; response not queued; next request 0x200.
- Redirect to 0x0000_0106 -> request address 0x0000_0104. PC 0xFFFF_FFFC fetch -> id_pc_plus4=0x0 and next request 0x0.
- Assert rst while in WAIT with 2 queued entries -> next cycle id_valid=0; first request after reset at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit
// Instruction fetch: PC, one-outstanding imem request, instruction queue to
// decode, and redirect handling with stale-response drop.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [6:0]      id_op
);

  localparam int                 c_PTR_W = $clog2(QDEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(QDEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_1 = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_1 = c_PTR_W'(1);
  localparam logic [XLEN-1:0]    c_FOUR  = XLEN'(4);
  localparam logic [XLEN-1:0]    c_ALIGN = ~XLEN'(3);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t              r_state;
  logic [XLEN-1:0]     r_pc;
  logic [XLEN-1:0]     r_req_pc;
  logic [XLEN-1:0]     r_q_instr [QDEPTH];
  logic [XLEN-1:0]     r_q_pc    [QDEPTH];
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_CNT_W-1:0]  r_count;

  logic                w_req_fire;
  logic                w_push;
  logic                w_pop;
  logic [XLEN-1:0]     w_redirect_pc;

  // Outputs are gated by rst so nothing handshakes during the reset cycle.
  assign imem_req_valid = ~rst && (r_state == S_REQ) && (r_count != c_FULL);
  assign imem_req_addr  = r_pc;
  assign id_valid       = ~rst && (r_count != '0);
  assign id_instr       = r_q_instr[r_rd_ptr];
  assign id_pc          = r_q_pc[r_rd_ptr];
  assign id_pc_plus4    = id_pc + c_FOUR;
  assign id_op          = id_instr[6:0];

  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_push         = (r_state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign w_pop          = id_valid && id_ready && !redirect_valid;
  assign w_redirect_pc  = redirect_pc & c_ALIGN;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_req_fire)
            r_state <= redirect_valid ? S_DROP : S_WAIT;
          if (w_req_fire && !redirect_valid)
            r_req_pc <= r_pc;
        end
        S_WAIT: begin
          if (imem_rsp_valid)
            r_state <= S_REQ;
          else if (redirect_valid)
            r_state <= S_DROP;
        end
        S_DROP: begin
          // Exactly one response is owed for the abandoned request.
          if (imem_rsp_valid)
            r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase

      if (redirect_valid)
        r_pc <= w_redirect_pc;
      else if (w_req_fire)
        r_pc <= r_pc + c_FOUR;

      if (redirect_valid) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_q_instr[r_wr_ptr] <= imem_rsp_data;
          r_q_pc[r_wr_ptr]    <= r_req_pc;
          r_wr_ptr            <= r_wr_ptr + c_PTR_1;
        end
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + c_PTR_1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_CNT_1;
          2'b01:   r_count <= r_count - c_CNT_1;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
